hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised forwarding and hazard controller for the integer pipeline. It generalises the fixed two-source, two-stage forwarding selector to NSRC source operands and NFWD forwarding stages, with youngest-stage priority. It adds load-use stall detection and a scoreboard for a single non-pipelined multi-cycle unit (mul/div), including its write-back pulse. It sits beside the ID/EX pipeline registers and drives the EX operand muxes, the PC/IF/ID hold, and the multi-cycle write-back port.

## Interface
Parameters:
- REG_W, 5: register address width.
- NSRC, 2: source operands per instruction.
- NFWD, 2: forwarding stages after EX. Index 0 = MEM (youngest), NFWD-1 = oldest.
- MC_LAT, 4: multi-cycle unit latency in cycles, from issue to write-back. Must be ≥ 1.
- SEL_W, $clog2(NFWD+1): width of each forward select field.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset. Synchronous and active-high; the single clock is `clk`.
- id_valid, input, 1: ID holds a real instruction.
- id_rs, input, NSRC*REG_W: ID source registers. Source i occupies bits [i*REG_W +: REG_W].
- id_mc, input, 1: ID instruction needs the multi-cycle unit.
- ex_rs, input, NSRC*REG_W: EX source registers.
- ex_rd, input, REG_W: EX destination register.
- ex_regwrite, input, 1: EX instruction writes a register.
- ex_memread, input, 1: EX instruction is a load.
- stg_rd, input, NFWD*REG_W: destination register of each forwarding stage.
- stg_regwrite, input, NFWD: regwrite flag of each forwarding stage.
- mc_issue, input, 1: EX issues a multi-cycle op this cycle.
- fwd_sel, output, NSRC*SEL_W: per-source select. 0 = register file; k = stage k-1.
- stall, output, 1: hold PC/IF/ID and insert a bubble into EX.
- mc_busy, output, 1: multi-cycle unit occupied.
- mc_done, output, 1: one-cycle write-back pulse.
- mc_done_rd, output, REG_W: write-back destination register, valid while mc_done is high.
- stall_cnt, output, 32: count of stalled cycles. See Configuration.

## Operation
- Forwarding: for each source i, fwd_sel[i] = k+1 for the lowest k with stg_regwrite[k], stg_rd[k] != 0 and stg_rd[k] == ex_rs[i]. Otherwise fwd_sel[i] = 0.
  - Register 0 is never forwarded.
  - With NFWD=2 the result equals the legacy MEM-over-WB priority.
- Scoreboard state:
  - busy (1 bit), rd_q (REG_W bits), cnt ($clog2(MC_LAT+1) bits).
  - IDLE (busy=0): on mc_issue, set busy=1, rd_q=ex_rd and cnt=MC_LAT.
  - BUSY: cnt decrements each cycle. When cnt==1, mc_done=1 and mc_done_rd=rd_q. On the next edge, busy=0 and cnt=0.
  - mc_issue while busy is a protocol violation and is ignored. The stall rules prevent it.
  - An issue with ex_rd==0 occupies the unit but causes no RAW stall.
- stall = id_valid AND any of:
  - Load-use: ex_memread && ex_regwrite && ex_rd != 0 && ex_rd matches any id_rs.
  - Scoreboard RAW: busy && rd_q != 0 && rd_q matches any id_rs.
  - Structural: id_mc && (busy || mc_issue).
- mc_busy = busy.

## Timing
- fwd_sel and stall are combinational from inputs and registered state; there is no added latency.
- mc_done and mc_done_rd decode registered state only (Moore outputs).
- An issue at edge t yields mc_done high during cycle t+MC_LAT-1 (counting the issue cycle as t). busy drops at edge t+MC_LAT.
- With MC_LAT=1, mc_done is high in the cycle right after the issue edge.
- A scoreboard RAW stall holds through the mc_done cycle and releases when busy=0. The register file provides the value; there is no mc bypass.
- Back-to-back use: an ID instruction with id_mc may leave ID in the cycle after mc_done.
- Reset values:
  - busy=0, cnt=0, rd_q=0.
  - mc_done=0, mc_done_rd=0, stall_cnt=0.
  - stall and fwd_sel follow the inputs.
- Reset mid-operation drops the in-flight op, and no mc_done is produced.

## Configuration
- HAZARD_PERF_EN defined: stall_cnt is a 32-bit register.
  - Increments on each cycle with stall=1 and saturates at 0xFFFFFFFF.
  - Clears on rst.
- HAZARD_PERF_EN undefined: stall_cnt is tied to 0 and no counter logic is built.

## Test plan
- Forwarding priority (NFWD=3, NSRC=2): ex_rs={5,5}; stg_rd={5,5,5}; all regwrite=1 -> fwd_sel={1,1}. Clear stg_regwrite[0] -> {2,2}. Set all stg_rd=0 with ex_rs={0,0} -> {0,0}.
- Load-use: ex_memread=1, ex_regwrite=1, ex_rd=7, id_rs[1]=7, id_valid=1 -> stall=1. With id_valid=0 -> stall=0. With ex_rd=0 -> stall=0.
- Multi-cycle (MC_LAT=4): mc_issue with ex_rd=9 at edge 0 -> mc_busy=1 during cycles 0..3. mc_done=1 with mc_done_rd=9 in cycle 3 only. id_rs[0]=9 stalls through cycle 3 and releases in cycle 4.
- Structural: unit busy and id_mc=1 -> stall=1 until busy clears. mc_issue and id_mc in the same cycle -> stall=1.
- Reset: rst asserted in cycle 2 of an MC_LAT=4 op -> busy=0 next cycle, no mc_done pulse, stall_cnt=0.
- Perf (HAZARD_PERF_EN): 10 stall cycles -> stall_cnt=10. Without the macro -> stall_cnt stays 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding select, load-use / scoreboard / structural
// stall detection and a scoreboard for one non-pipelined multi-cycle unit.
// Optional feature macro: HAZARD_PERF_EN builds a saturating 32-bit stall
// counter on stall_cnt; without it stall_cnt is tied to zero.
//
// Handshake: mc_issue is a single-cycle strobe with no ready; it is accepted
// only while the unit is idle, and the stall logic keeps an issue from being
// presented while busy (an issue seen while busy is dropped).
`timescale 1ns/1ps
module hazard_ctrl #(
  parameter int REG_W  = 5,
  parameter int NSRC   = 2,
  parameter int NFWD   = 2,
  parameter int MC_LAT = 4,
  parameter int SEL_W  = $clog2(NFWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [NSRC*REG_W-1:0]   id_rs,
  input  logic                    id_mc,
  input  logic [NSRC*REG_W-1:0]   ex_rs,
  input  logic [REG_W-1:0]        ex_rd,
  input  logic                    ex_regwrite,
  input  logic                    ex_memread,
  input  logic [NFWD*REG_W-1:0]   stg_rd,
  input  logic [NFWD-1:0]         stg_regwrite,
  input  logic                    mc_issue,
  output logic [NSRC*SEL_W-1:0]   fwd_sel,
  output logic                    stall,
  output logic                    mc_busy,
  output logic                    mc_done,
  output logic [REG_W-1:0]        mc_done_rd,
  output logic [31:0]             stall_cnt
);

  localparam int CNT_W = $clog2(MC_LAT + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             state_q;
  logic [REG_W-1:0]   rd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mc_done_q;
  logic [REG_W-1:0]   mc_done_rd_q;

  logic load_hit;
  logic sb_hit;
  logic load_use;
  logic sb_raw;
  logic structural;

  // Forward select: the youngest matching stage wins, so scan oldest to
  // youngest and let later (younger) matches overwrite.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (stg_regwrite[k] && (stg_rd[k*REG_W +: REG_W] != '0) &&
            (stg_rd[k*REG_W +: REG_W] == ex_rs[i*REG_W +: REG_W])) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  // Source-match scan of the ID operands against the EX load and the
  // pending multi-cycle destination.
  always_comb begin
    load_hit = 1'b0;
    sb_hit   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_rs[i*REG_W +: REG_W] == ex_rd) load_hit = 1'b1;
      if (id_rs[i*REG_W +: REG_W] == rd_q)  sb_hit   = 1'b1;
    end
  end

  assign load_use   = ex_memread && ex_regwrite && (ex_rd != '0) && load_hit;
  assign sb_raw     = (state_q == ST_BUSY) && (rd_q != '0) && sb_hit;
  assign structural = id_mc && ((state_q == ST_BUSY) || mc_issue);
  assign stall      = id_valid && (load_use || sb_raw || structural);

  // Scoreboard FSM; the write-back pulse is registered one cycle ahead so
  // it is high exactly in the cycle where the remaining count is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rd_q         <= '0;
      cnt_q        <= '0;
      mc_done_q    <= 1'b0;
      mc_done_rd_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mc_issue) begin
            state_q      <= ST_BUSY;
            rd_q         <= ex_rd;
            cnt_q        <= CNT_W'(MC_LAT);
            mc_done_q    <= (MC_LAT == 1);
            mc_done_rd_q <= (MC_LAT == 1) ? ex_rd : '0;
          end
        end
        ST_BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mc_done_q    <= 1'b0;
            mc_done_rd_q <= '0;
          end else begin
            cnt_q        <= cnt_q - 1'b1;
            mc_done_q    <= (cnt_q == CNT_W'(2));
            mc_done_rd_q <= (cnt_q == CNT_W'(2)) ? rd_q : '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mc_busy    = (state_q == ST_BUSY);
  assign mc_done    = mc_done_q;
  assign mc_done_rd = mc_done_rd_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl (NSRC=2, NFWD=3, MC_LAT=4) with a behavioural
// model: forwarding by first-match search, the multi-cycle unit as a queue
// of pending write-backs stamped with their issue cycle.
`timescale 1ns/1ps
module tb_hazard_ctrl;
  localparam int REG_W  = 5;
  localparam int NSRC   = 2;
  localparam int NFWD   = 3;
  localparam int MC_LAT = 4;
  localparam int SEL_W  = $clog2(NFWD + 1);

  logic                  clk;
  logic                  rst;
  logic                  id_valid;
  logic [NSRC*REG_W-1:0] id_rs;
  logic                  id_mc;
  logic [NSRC*REG_W-1:0] ex_rs;
  logic [REG_W-1:0]      ex_rd;
  logic                  ex_regwrite;
  logic                  ex_memread;
  logic [NFWD*REG_W-1:0] stg_rd;
  logic [NFWD-1:0]       stg_regwrite;
  logic                  mc_issue;
  logic [NSRC*SEL_W-1:0] fwd_sel;
  logic                  stall;
  logic                  mc_busy;
  logic                  mc_done;
  logic [REG_W-1:0]      mc_done_rd;
  logic [31:0]           stall_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model state: pending write-backs and the cycle the head op was issued.
  logic [REG_W-1:0] exp_q[$];
  int               m_issue_cyc = 0;
  logic [31:0]      m_cnt = 0;

  hazard_ctrl #(
    .REG_W(REG_W), .NSRC(NSRC), .NFWD(NFWD), .MC_LAT(MC_LAT)
  ) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_mc(id_mc),
    .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .stg_rd(stg_rd), .stg_regwrite(stg_regwrite),
    .mc_issue(mc_issue), .fwd_sel(fwd_sel), .stall(stall), .mc_busy(mc_busy),
    .mc_done(mc_done), .mc_done_rd(mc_done_rd), .stall_cnt(stall_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [NSRC*SEL_W-1:0] model_fwd();
    logic [NSRC*SEL_W-1:0] r;
    r = '0;
    for (int i = 0; i < NSRC; i++) begin
      int sel;
      sel = 0;
      for (int k = 0; k < NFWD; k++) begin
        if (sel == 0 && stg_regwrite[k] && stg_rd[k*REG_W +: REG_W] != 0 &&
            stg_rd[k*REG_W +: REG_W] == ex_rs[i*REG_W +: REG_W])
          sel = k + 1;
      end
      r[i*SEL_W +: SEL_W] = SEL_W'(sel);
    end
    return r;
  endfunction

  function automatic bit id_reads(input logic [REG_W-1:0] r);
    bit hit;
    hit = 0;
    for (int i = 0; i < NSRC; i++)
      if (id_rs[i*REG_W +: REG_W] == r) hit = 1;
    return hit;
  endfunction

  function automatic bit model_busy();
    return exp_q.size() != 0;
  endfunction

  function automatic bit model_done();
    return model_busy() && (cyc == m_issue_cyc + MC_LAT - 1);
  endfunction

  function automatic logic [REG_W-1:0] model_done_rd();
    return model_done() ? exp_q[0] : '0;
  endfunction

  function automatic bit model_stall();
    bit lu, raw, st;
    lu  = ex_memread && ex_regwrite && ex_rd != 0 && id_reads(ex_rd);
    raw = model_busy() && exp_q[0] != 0 && id_reads(exp_q[0]);
    st  = id_mc && (model_busy() || mc_issue);
    return id_valid && (lu || raw || st);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    id_valid = 0; id_rs = '0; id_mc = 0; ex_rs = '0; ex_rd = '0;
    ex_regwrite = 0; ex_memread = 0; stg_rd = '0; stg_regwrite = '0;
    mc_issue = 0;
  endtask

  // Advance one clock edge and update the model with the inputs at that edge.
  task automatic tick();
    bit st;
    st = model_stall();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
`ifdef HAZARD_PERF_EN
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
      if (model_busy()) begin
        if (cyc + 1 >= m_issue_cyc + MC_LAT) void'(exp_q.pop_front());
      end else if (mc_issue) begin
        exp_q.push_back(ex_rd);
        m_issue_cyc = cyc + 1;
      end
    end
    cyc++;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    total++; if (mc_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", mc_busy); end
    total++; if (mc_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", mc_done); end
    total++; if (mc_done_rd !== '0) begin bad++; $display("FAIL reset_done_rd got=%0d exp=0", mc_done_rd); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    rst = 0;
    tick();
  endtask

  task automatic test_fwd_priority();
    clear_inputs();
    ex_rs = {5'd5, 5'd5}; stg_rd = {5'd5, 5'd5, 5'd5}; stg_regwrite = 3'b111;
    #1;
    total++; if (fwd_sel !== 4'b0101) begin bad++; $display("FAIL fwd_youngest got=%h exp=5", fwd_sel); end
    stg_regwrite = 3'b110;
    #1;
    total++; if (fwd_sel !== 4'b1010) begin bad++; $display("FAIL fwd_second got=%h exp=a", fwd_sel); end
    stg_rd = '0; ex_rs = '0; stg_regwrite = 3'b111;
    #1;
    total++; if (fwd_sel !== 4'b0000) begin bad++; $display("FAIL fwd_reg0 got=%h exp=0", fwd_sel); end
    for (int n = 0; n < 60; n++) begin
      ex_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      stg_rd       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      stg_regwrite = 3'($urandom_range(0, 7));
      #1;
      total++; if (fwd_sel !== model_fwd()) begin bad++; $display("FAIL fwd_rand n=%0d got=%h exp=%h", n, fwd_sel, model_fwd()); end
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 7; id_rs[1*REG_W +: REG_W] = 7; id_valid = 1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_use got=%0b exp=1", stall); end
    id_valid = 0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_use_novalid got=%0b exp=0", stall); end
    id_valid = 1; ex_rd = 0; id_rs = '0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_use_r0 got=%0b exp=0", stall); end
    ex_rd = 7; id_rs[1*REG_W +: REG_W] = 7; ex_memread = 0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_use_noload got=%0b exp=0", stall); end
    clear_inputs();
  endtask

  task automatic test_multicycle();
    clear_inputs();
    ex_rd = 9; mc_issue = 1;
    tick();
    mc_issue = 0; ex_rd = 0; id_valid = 1; id_rs[0 +: REG_W] = 9;
    for (int c = 0; c <= MC_LAT; c++) begin
      #1;
      total++; if (mc_busy !== (c < MC_LAT)) begin bad++; $display("FAIL mc_busy c=%0d got=%0b exp=%0b", c, mc_busy, c < MC_LAT); end
      total++; if (mc_done !== (c == MC_LAT - 1)) begin bad++; $display("FAIL mc_done c=%0d got=%0b exp=%0b", c, mc_done, c == MC_LAT - 1); end
      total++; if (mc_done_rd !== ((c == MC_LAT - 1) ? 5'd9 : 5'd0)) begin bad++; $display("FAIL mc_done_rd c=%0d got=%0d", c, mc_done_rd); end
      total++; if (stall !== (c < MC_LAT)) begin bad++; $display("FAIL mc_raw_stall c=%0d got=%0b exp=%0b", c, stall, c < MC_LAT); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_structural();
    int stalled;
    clear_inputs();
    id_valid = 1; id_mc = 1; mc_issue = 1; ex_rd = 3;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL struct_same_cycle got=%0b exp=1", stall); end
    tick();
    mc_issue = 0; ex_rd = 0;
    stalled = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++; if (stall !== model_busy()) begin bad++; $display("FAIL struct_stall c=%0d got=%0b exp=%0b", c, stall, model_busy()); end
      if (stall === 1'b1) stalled++;
      tick();
    end
    total++; if (stalled != MC_LAT) begin bad++; $display("FAIL struct_len got=%0d exp=%0d", stalled, MC_LAT); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    int pulses;
    clear_inputs();
    ex_rd = 11; mc_issue = 1;
    tick();
    mc_issue = 0; ex_rd = 0;
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    total++; if (mc_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%0b exp=0", mc_busy); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=0", stall_cnt); end
    pulses = 0;
    for (int c = 0; c < MC_LAT + 2; c++) begin
      if (mc_done === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rst_mid_done got=%0d pulses exp=0", pulses); end
  endtask

  task automatic test_perf();
    logic [31:0] want;
`ifdef HAZARD_PERF_EN
    want = 32'd10;
`else
    want = 32'd0;
`endif
    clear_inputs();
    rst = 1; tick(); rst = 0;
    ex_memread = 1; ex_regwrite = 1; ex_rd = 4; id_rs[0 +: REG_W] = 4; id_valid = 1;
    for (int c = 0; c < 10; c++) tick();
    clear_inputs();
    #1;
    total++; if (stall_cnt !== want) begin bad++; $display("FAIL perf_count got=%0d exp=%0d", stall_cnt, want); end
    total++; if (stall_cnt !== m_cnt) begin bad++; $display("FAIL perf_model got=%0d exp=%0d", stall_cnt, m_cnt); end
  endtask

  task automatic test_random();
    clear_inputs();
    rst = 1; tick(); rst = 0;
    for (int n = 0; n < 500; n++) begin
      rst          = ($urandom_range(0, 80) == 0);
      id_valid     = 1'($urandom_range(0, 1));
      id_mc        = ($urandom_range(0, 3) == 0);
      id_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ex_rs        = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ex_rd        = 5'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_memread   = ($urandom_range(0, 2) == 0);
      stg_rd       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      stg_regwrite = 3'($urandom_range(0, 7));
      mc_issue     = ($urandom_range(0, 3) == 0);
      #1;
      total++; if (fwd_sel !== model_fwd()) begin bad++; $display("FAIL rnd_fwd n=%0d got=%h exp=%h", n, fwd_sel, model_fwd()); end
      total++; if (stall !== model_stall()) begin bad++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, stall, model_stall()); end
      total++; if (mc_busy !== model_busy()) begin bad++; $display("FAIL rnd_busy n=%0d got=%0b exp=%0b", n, mc_busy, model_busy()); end
      total++; if (mc_done !== model_done()) begin bad++; $display("FAIL rnd_done n=%0d got=%0b exp=%0b", n, mc_done, model_done()); end
      total++; if (mc_done_rd !== model_done_rd()) begin bad++; $display("FAIL rnd_done_rd n=%0d got=%0d exp=%0d", n, mc_done_rd, model_done_rd()); end
      total++; if (stall_cnt !== m_cnt) begin bad++; $display("FAIL rnd_stall_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_cnt); end
      tick();
    end
    rst = 0;
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_multicycle();
    test_structural();
    test_reset_mid();
    test_perf();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
